// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: load width codes,
// rd source select codes and the writeback FSM state encoding.
package urv_writeback_pkg;

    // Load/store width and sign codes carried in x_fun_i
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    // Source of the rd value for non-load instructions
    localparam logic [1:0] RD_SOURCE_ALU      = 2'b00;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'b01;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'b10;
    localparam logic [1:0] RD_SOURCE_CSR      = 2'b11;

    // Writeback FSM: waiting for nothing, waiting for load data,
    // or holding load data that arrived while the pipeline was stalled
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HELD = 2'b10
    } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// Extracts the addressed byte/halfword from a 32-bit load word and
// sign- or zero-extends it according to the load width code.
module urv_load_align
    import urv_writeback_pkg::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the byte and halfword lanes addressed by the low address bits
    always_comb begin
        byte_sel = data[7:0];
        case (addr)
            2'd0: byte_sel = data[7:0];
            2'd1: byte_sel = data[15:8];
            2'd2: byte_sel = data[23:16];
            2'd3: byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
        half_sel = addr[1] ? data[31:16] : data[15:0];
    end

    // Extend the selected lane; unknown width codes fall back to a full word
    always_comb begin
        result = data;
        case (fun)
            LDST_B:  result = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: result = {24'h0, byte_sel};
            LDST_H:  result = {{16{half_sel[15]}}, half_sel};
            LDST_HU: result = {16'h0, half_sel};
            LDST_L:  result = data;
            default: result = data;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: waits for load data, aligns it, selects the final
// rd value and issues one registered register-file write per retired
// instruction. Load data returning during a global stall is parked in a
// one-entry holding register until the stall releases.
module urv_writeback
    import urv_writeback_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        w_stall_i,
    output logic        w_stall_req_o,

    input  logic        x_valid_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [31:0] x_rd_shifter_i,
    input  logic [31:0] x_rd_multiply_i,
    input  logic [31:0] x_dm_addr_i,

    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,

    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o
);

    wb_state_t   state_q;
    wb_state_t   state_d;
    logic [31:0] hold_q;
    logic        capture;
    logic        data_avail;
    logic [31:0] load_data;
    logic [31:0] load_aligned;
    logic [31:0] rd_value;
    logic        retire;
    logic        write_en;

    // Stores retire without waiting, so the store flag and the upper
    // address bits have no effect on writeback
    logic unused_inputs;
    assign unused_inputs = ^{x_store_i, x_dm_addr_i[31:2]};

    // Load data is usable either straight off the bus or from the holding register
    assign data_avail = dm_load_done_i | (state_q == ST_HELD);
    assign load_data  = (state_q == ST_HELD) ? hold_q : dm_data_l_i;

    urv_load_align u_load_align (
        .fun    (x_fun_i),
        .addr   (x_dm_addr_i[1:0]),
        .data   (load_data),
        .result (load_aligned)
    );

    // Final rd value: aligned load data, otherwise the selected execute result
    always_comb begin
        rd_value = x_rd_value_i;
        if (x_load_i) begin
            rd_value = load_aligned;
        end else begin
            case (x_rd_source_i)
                RD_SOURCE_SHIFTER:  rd_value = x_rd_shifter_i;
                RD_SOURCE_MULTIPLY: rd_value = x_rd_multiply_i;
                default:            rd_value = x_rd_value_i;
            endcase
        end
    end

    // Retire and write-enable decisions; x0 is never written
    assign retire   = x_valid_i & ~w_stall_i & (~x_load_i | data_avail);
    assign write_en = retire & x_rd_write_i & (x_rd_i != 5'd0);

    // Ask for a stall only while a load's data has neither arrived nor been parked
    assign w_stall_req_o = x_valid_i & x_load_i & ~data_avail;

    // Next-state logic and decision to park returning load data
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (x_valid_i && x_load_i) begin
                    if (!dm_load_done_i) begin
                        state_d = ST_WAIT;
                    end else if (w_stall_i) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                    end
                end
            end
            ST_WAIT: begin
                if (dm_load_done_i) begin
                    if (w_stall_i) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HELD: begin
                if (!w_stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and load data holding register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_q <= dm_data_l_i;
            end
        end
    end

    // Register-file write port: write strobe pulses per retire, index/data hold otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_rd_o       <= 5'd0;
            rf_rd_value_o <= 32'h0;
            rf_rd_write_o <= 1'b0;
        end else begin
            rf_rd_write_o <= write_en;
            if (retire) begin
                rf_rd_o       <= x_rd_i;
                rf_rd_value_o <= rd_value;
            end
        end
    end

endmodule

// File: doc/urv_writeback.md
# urv_writeback

Writeback stage of the uRV pipeline, directly downstream of the execute stage. It consumes the execute stage's registered W-stage bundle, waits for outstanding data-memory loads, aligns and sign-extends load data, selects the final rd value, and issues one registered register-file write per retired instruction. A 3-state FSM with a one-entry data holding register absorbs load data that returns while the pipeline is stalled elsewhere.

## Interface
Parameters: none.
- clk_i  in  1  pipeline clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- w_stall_i  in  1  global stall; stage holds and retires nothing
- w_stall_req_o  out  1  stall request while a load's data is outstanding
- x_valid_i  in  1  W-stage bundle valid
- x_fun_i  in  3  load width/sign code (urv_defs LDST_*)
- x_load_i / x_store_i  in  1  instruction is load / store
- x_rd_i  in  5  destination register
- x_rd_write_i  in  1  instruction writes rd
- x_rd_source_i  in  2  urv_defs RD_SOURCE_* (ALU/CSR, SHIFTER, MULTIPLY)
- x_rd_value_i  in  32  ALU/CSR result
- x_rd_shifter_i / x_rd_multiply_i  in  32  shifter / multiplier results
- x_dm_addr_i  in  32  load address (bits [1:0] used)
- dm_data_l_i  in  32  load data, valid with dm_load_done_i
- dm_load_done_i  in  1  one-cycle load completion strobe
- rf_rd_o  out  5  register-file write index
- rf_rd_value_o  out  32  register-file write data
- rf_rd_write_o  out  1  register-file write enable (one pulse per retire)

## Operation
- FSM states: IDLE, WAIT (load valid, no data yet), HELD (data captured, stage stalled).
- IDLE: x_valid_i & x_load_i & !dm_load_done_i -> WAIT. If dm_load_done_i arrives with w_stall_i=1 -> capture dm_data_l_i into hold_q -> HELD.
- WAIT: dm_load_done_i & !w_stall_i -> retire, IDLE. dm_load_done_i & w_stall_i -> capture, HELD.
- HELD: !w_stall_i -> retire from hold_q, IDLE. Further dm_load_done_i pulses in HELD are ignored.
- data_avail = dm_load_done_i | (state==HELD). Load data source is hold_q when HELD, else dm_data_l_i.
- Alignment: B/BU select byte x_dm_addr_i[1:0]; H/HU select half x_dm_addr_i[1]; L full word. B and H sign-extend; BU and HU zero-extend. Any other fun code -> word.
- rd mux: x_load_i -> aligned load; else by x_rd_source_i: SHIFTER, MULTIPLY, default x_rd_value_i.
- Retire condition: x_valid_i & !w_stall_i & (!x_load_i | data_avail). Non-load and store instructions retire immediately, without waiting for the store to complete.
- Write enable: rf_rd_write_o = retire & x_rd_write_i & (x_rd_i != 0). x0 is never written.
- w_stall_req_o = x_valid_i & x_load_i & !data_avail (combinational).

## Timing
- Reset values: all outputs 0; state IDLE; hold_q 0. Reset mid-load returns to IDLE and drops held data with no write.
- rf_rd_o, rf_rd_value_o and rf_rd_write_o are registered: retire in cycle T -> write visible in T+1, for exactly one cycle.
- When the bus answers in the same cycle, a load adds zero latency; otherwise w_stall_req_o stays high from the first cycle until dm_load_done_i.
- w_stall_i high: no retire and no write. rf_rd_write_o falls to 0 and the other rf outputs hold.
- The stage must not stall on its own request when data is captured in HELD; w_stall_req_o is 0 in HELD.

## Structure
- LDST_*, RD_SOURCE_* and the FSM state encodings belong in urv_defs.v.
- One sub-module, urv_load_align: combinational fun/addr/data to 32-bit aligned result.

## Test plan
- Word load, addr 0x100, dm_load_done_i in the same cycle with data 0xDEADBEEF, rd=5 -> no stall; next cycle rf_rd_write_o=1, rf_rd_o=5, value 0xDEADBEEF.
- LB, addr[1:0]=3, data 0x80112233 -> 0xFFFFFF80. LBU same inputs -> 0x00000080. LH, addr[1]=1 -> 0xFFFF8011.
- Load with done 3 cycles late -> w_stall_req_o high for 3 cycles; single write pulse afterwards.
- Done arrives while w_stall_i=1 for 2 cycles, data 0x12345678 -> HELD; write of 0x12345678 one cycle after stall release. A second done pulse in HELD is ignored.
- ALU op with rd=0 and x_rd_write_i=1 -> rf_rd_write_o stays 0. SHIFTER source with value 0xF0 and rd=7 -> 0xF0 written to r7.
- Assert rst_i while in WAIT -> outputs 0 and state IDLE immediately; no write after reset release.
